// File: rtl/fp_square_seq.sv
// Sequential IEEE754 single-precision squarer using an iterative shift-add mantissa multiplier.
// Optional special-case decode (zero/inf/NaN, overflow saturation, underflow flush) under `FP_SQUARE_SPECIAL_EN.
module fp_square_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_sq
);
    localparam int         N        = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LOAD = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      r_state;
    logic [47:0] r_acc;
    logic [47:0] r_mcand;
    logic [23:0] r_mplier;
    logic [4:0]  r_count;
    logic [7:0]  r_exp;
    logic [22:0] r_frac;
    logic        r_outValid;
    logic [31:0] r_fSq;

    logic [47:0]       w_partial;
    logic              w_p47;
    logic [22:0]       w_mant;
    logic signed [9:0] w_e;
    logic [31:0]       w_result;
    logic              w_unused;

    // Partial product for the multiplier bits retired this cycle, LSB first.
    always_comb begin
        w_partial = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (r_mplier[b]) begin
                w_partial = w_partial + (r_mcand << b);
            end
        end
    end

    assign w_p47  = r_acc[47];
    assign w_mant = w_p47 ? r_acc[46:24] : r_acc[45:23];
    assign w_e    = $signed({1'b0, r_exp, 1'b0}) - 10'sd127 + $signed({9'd0, w_p47});

`ifdef FP_SQUARE_SPECIAL_EN
    always_comb begin
        if (r_exp == 8'd0) begin
            w_result = 32'h0000_0000;
        end else if (r_exp == 8'hFF) begin
            w_result = (r_frac != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        end else if (w_e >= 10'sd255) begin
            w_result = 32'h7F80_0000;
        end else if (w_e <= 10'sd0) begin
            w_result = 32'h0000_0000;
        end else begin
            w_result = {1'b0, w_e[7:0], w_mant};
        end
    end
`else
    // Raw multiplier behaviour: exponent wraps modulo 256, no special decode.
    assign w_result = {1'b0, w_e[7:0], w_mant};
`endif

    // Sign is always discarded; the exponent high bits and fraction are only consumed by the special decode.
    assign w_unused = ^{A[31], w_e[9:8], r_frac};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_count    <= '0;
            r_exp      <= '0;
            r_frac     <= '0;
            r_outValid <= 1'b0;
            r_fSq      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_exp    <= A[30:23];
                        r_frac   <= A[22:0];
                        r_mcand  <= {24'd0, 1'b1, A[22:0]};
                        r_mplier <= {1'b1, A[22:0]};
                        r_acc    <= '0;
                        r_count  <= CNT_LOAD;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    r_acc    <= r_acc + w_partial;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    if (r_count == 5'd0) begin
                        r_state <= NORM;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                NORM: begin
                    r_fSq      <= w_result;
                    r_outValid <= 1'b1;
                    r_state    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = r_outValid;
    assign f_sq      = r_fSq;

endmodule

// File: tb/tb_fp_square_seq.sv
// Scoreboard bench for fp_square_seq: four instances (BITS_PER_CYCLE 1,2,4,8) share one operand stream
// and are checked against an arithmetic reference model for result, latency and handshake behaviour.
module tb_fp_square_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] opA = '0;
    logic [3:0]  inReady;
    logic [3:0]  outValid;
    logic [3:0]  outReady = 4'hF;
    logic [31:0] fSq [4];

    int          tests = 0;
    int          fails = 0;
    int          edgeCnt = 0;
    logic [31:0] expQ[$];
    int          rdIdx [4] = '{0, 0, 0, 0};
    int          acceptEdge [4] = '{0, 0, 0, 0};
    logic [3:0]  prevValid = '0;
    logic [3:0]  prevReady = '0;
    logic        prevReset = 1'b1;
    logic [31:0] lastF [4];
    logic        randReady = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : gDut
        fp_square_seq #(.BITS_PER_CYCLE(1 << k)) uDut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (inValid),
            .in_ready (inReady[k]),
            .A        (opA),
            .out_valid(outValid[k]),
            .out_ready(outReady[k]),
            .f_sq     (fSq[k])
        );
    end

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    always @(posedge clk) begin
        #2;
        if (randReady) outReady = 4'($urandom);
    end

    // Reference: full 24x24 product with plain arithmetic, then normalise and truncate.
    function automatic logic [31:0] modelSquare(input logic [31:0] a);
        logic [47:0] prod;
        logic [22:0] mant;
        int          ex;
        int          e;
        ex   = int'(a[30:23]);
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, a[22:0]};
        if (prod >= 48'h8000_0000_0000) begin
            mant = prod[46:24];
            e    = 2 * ex - 127 + 1;
        end else begin
            mant = prod[45:23];
            e    = 2 * ex - 127;
        end
`ifdef FP_SQUARE_SPECIAL_EN
        if (ex == 0) return 32'h0000_0000;
        if (ex == 255) return (a[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (e >= 255) return 32'h7F80_0000;
        if (e <= 0) return 32'h0000_0000;
`endif
        return {1'b0, 8'(e), mant};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: acceptance bookkeeping, result pop/compare, latency, hold and drop behaviour.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset && inValid && inReady[k]) acceptEdge[k] = edgeCnt;
            if (outValid[k] && !prevValid[k]) begin
                checkOutput($sformatf("latency_bpc%0d", 1 << k),
                            32'(edgeCnt - 1 - acceptEdge[k]), 32'((24 >> k) + 1));
                if (rdIdx[k] < expQ.size()) begin
                    checkOutput($sformatf("result_bpc%0d", 1 << k), fSq[k], expQ[rdIdx[k]]);
                    rdIdx[k]++;
                end else begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL spurious_bpc%0d: got output %h, expected none", 1 << k, fSq[k]);
                end
            end else if (!prevReset && prevValid[k] && !prevReady[k]) begin
                checkOutput($sformatf("holdValid_bpc%0d", 1 << k), 32'(outValid[k]), 32'd1);
                checkOutput($sformatf("holdData_bpc%0d", 1 << k), fSq[k], lastF[k]);
            end else if (!prevReset && prevValid[k] && prevReady[k]) begin
                checkOutput($sformatf("dropValid_bpc%0d", 1 << k), 32'(outValid[k]), 32'd0);
            end
            prevValid[k] = outValid[k];
            prevReady[k] = outReady[k];
            lastF[k]     = fSq[k];
        end
        prevReset = reset;
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] expected);
        int guard = 0;
        while (inReady != 4'hF && guard < 300) begin
            stepCycle();
            guard++;
        end
        if (inReady != 4'hF) checkOutput("readyTimeout", 32'(inReady), 32'hF);
        inValid = 1'b1;
        opA     = a;
        expQ.push_back(expected);
        stepCycle();
        inValid = 1'b0;
    endtask

    function automatic bit allRead();
        for (int k = 0; k < 4; k++) if (rdIdx[k] != expQ.size()) return 1'b0;
        return 1'b1;
    endfunction

    task automatic waitDrain();
        int guard = 0;
        while ((inReady != 4'hF || !allRead()) && guard < 400) begin
            stepCycle();
            guard++;
        end
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("drain_bpc%0d", 1 << k), 32'(rdIdx[k]), 32'(expQ.size()));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int guard;

        repeat (3) stepCycle();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rstValid_bpc%0d", 1 << k), 32'(outValid[k]), 32'd0);
            checkOutput($sformatf("rstData_bpc%0d", 1 << k), fSq[k], 32'h0);
        end
        checkOutput("rstInReady", 32'(inReady), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("inReadyAfterRst", 32'(inReady), 32'hF);
        stepCycle();

        $display("[TB] directed operands");
        applyStimulus(32'h4000_0000, 32'h4080_0000);
        applyStimulus(32'hC040_0000, 32'h4110_0000);
        applyStimulus(32'h3FB5_04F3, 32'h3FFF_FFFF);
`ifdef FP_SQUARE_SPECIAL_EN
        applyStimulus(32'h7F00_0000, 32'h7F80_0000);
        applyStimulus(32'h0000_0000, 32'h0000_0000);
        applyStimulus(32'h7FC0_0001, 32'h7FC0_0000);
`else
        applyStimulus(32'h0000_0000, 32'h4080_0000);
`endif
        waitDrain();

        $display("[TB] backpressure");
        outReady = 4'h0;
        applyStimulus(32'h4000_0000, 32'h4080_0000);
        guard = 0;
        while (!outValid[0] && guard < 100) begin
            stepCycle();
            guard++;
        end
        checkOutput("bpOutValid", 32'(outValid[0]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                inValid = 1'b1;
                opA     = 32'h4040_0000;
                checkOutput("bpInReady", 32'(inReady), 32'h0);
            end else begin
                inValid = 1'b0;
            end
            stepCycle();
        end
        inValid  = 1'b0;
        outReady = 4'hF;
        waitDrain();

        $display("[TB] reset during MUL");
        applyStimulus(32'h4040_0000, 32'h4110_0000);
        repeat (9) stepCycle();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) rdIdx[k] = expQ.size();
        #1;
        checkOutput("readyAfterAbort", 32'(inReady), 32'hF);
        repeat (30) stepCycle();
        applyStimulus(32'h3F80_0000, 32'h3F80_0000);
        waitDrain();

        $display("[TB] randomized operands with random out_ready");
        randReady = 1'b1;
        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            applyStimulus(r, modelSquare(r));
        end
        randReady = 1'b0;
        @(posedge clk);
        #3;
        outReady = 4'hF;
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
